watchdog_controller: RTL
========================

Name: watchdog_controller

Overview:
Cycle-based watchdog sequencer shared by up to NUM_REQ verification components (truss/teal agents). Requesters arm, kick, disarm and acknowledge a single timeout counter through a round-robin arbitrated valid/ready command port. The block raises timeout when the armed count expires. If nobody acknowledges within a post-timeout window, it raises a sticky hung flag that the top-level uses to end simulation.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
COUNTER_WIDTH, 64, width of main timeout counter and cfg_timeout
POST_COUNTER_WIDTH, 8, width of post-timeout counter and cfg_post
ID_W, $clog2(NUM_REQ), requester index width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_cmd  in  2*NUM_REQ  per-requester command, requester i at bits [2i+1:2i]
req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and the RR pointer
cfg_timeout  in  COUNTER_WIDTH  reload value for ARM/KICK, in cycles
cfg_post  in  POST_COUNTER_WIDTH  post-timeout window, in cycles
timeout  out  1  high while state is TIMEOUT or HUNG
hung  out  1  sticky until reset
state  out  2  IDLE=0, ARMED=1, TIMEOUT=2, HUNG=3
count  out  COUNTER_WIDTH  current main counter value
last_owner  out  ID_W  index of the last requester whose command was accepted
cmd_err  out  1  one-cycle pulse: the accepted command was illegal in the current state

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, count=0, post counter=0, timeout=0, hung=0, last_owner=0, cmd_err=0, RR pointer=0. Reset mid-operation aborts any state, including HUNG.
- Commands: ARM=0, KICK=1, DISARM=2, ACK=3.
- Handshake: a command transfers when req_valid[i]&&req_ready[i] at posedge. A requester holds valid and cmd stable until ready. At most one grant per cycle.
- Arbitration: round-robin. Search starts at the pointer and wraps. After a grant to i, pointer=(i+1) mod NUM_REQ. With no valid requests, the pointer holds and no grant is issued.
- Grants are issued in every state, including HUNG. An accepted command updates last_owner.
- IDLE:
  - ARM: count=cfg_timeout, go to ARMED.
  - KICK/DISARM/ACK: cmd_err=1, no state change.
- ARMED:
  - An accepted command takes priority over expiry in the same cycle.
  - ARM/KICK: count=cfg_timeout.
  - DISARM: go to IDLE, count=0.
  - ACK: cmd_err=1.
  - No command and count==0: go to TIMEOUT, post=cfg_post.
  - No command and count!=0: count-1.
  - Timeout therefore rises cfg_timeout+1 cycles after the ARM/KICK edge. cfg_timeout=0 gives timeout one cycle after arm.
- TIMEOUT:
  - ACK: go to IDLE, count=0, timeout drops next cycle.
  - Other commands: cmd_err=1, no effect.
  - No ACK and post==0: go to HUNG, hung=1.
  - No ACK and post!=0: post-1.
  - An ACK in the same cycle that post reaches 0 wins.
- HUNG: terminal. All commands give cmd_err=1. Only reset exits.
- Counters never wrap: decrement happens only when the counter is nonzero.
- cfg_timeout and cfg_post are sampled only at load events. Changing them mid-count has no effect until the next load.
- All outputs are registered except req_ready.

Decomposition:
- Package watchdog_ctrl_pkg holds:
  - cmd_t enum (ARM, KICK, DISARM, ACK)
  - state_t enum (IDLE, ARMED, TIMEOUT, HUNG)
  - constants for default cfg values (10_000_000 cycles, 100 cycles)
- Sub-module watchdog_rr_arbiter(NUM_REQ):
  - inputs: req, advance
  - outputs: one-hot gnt, gnt_id, gnt_valid
  - owns the RR pointer and uses the same synchronous active-low reset
- The top contains the FSM, both counters and the command decode.

Test Plan:
- ARM from req0 with cfg_timeout=5, no further commands -> state=ARMED; timeout=1 exactly 6 cycles after the ARM edge; count sequence 5,4,3,2,1,0.
- ARM (cfg_timeout=3), then KICK when count==0 -> count reloads to 3, no timeout; next timeout 4 cycles after the kick.
- Reach TIMEOUT with cfg_post=2, no ACK -> HUNG and hung=1 three cycles after entering TIMEOUT; a later ACK gives cmd_err pulse, hung remains set.
- Reach TIMEOUT, ACK from req2 on the cycle post==0 -> state=IDLE, hung=0, last_owner=2.
- All four requesters hold valid with KICK while ARMED -> grants in order 0,1,2,3,0; exactly one-hot each cycle; the pointer wraps.
- KICK in IDLE -> cmd_err pulses for one cycle, state stays IDLE. Reset asserted while in HUNG -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/watchdog_ctrl_pkg.sv
// Shared types and constants for the watchdog sequencer: command/state encodings
// and the configuration values a top level would normally tie to cfg_timeout/cfg_post.
package watchdog_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_ARM    = 2'd0,
        CMD_KICK   = 2'd1,
        CMD_DISARM = 2'd2,
        CMD_ACK    = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_HUNG    = 2'd3
    } state_t;

    localparam logic [63:0] DEFAULT_CFG_TIMEOUT = 64'd10_000_000;
    localparam logic [7:0]  DEFAULT_CFG_POST    = 8'd100;

    // A state in which the timeout output is asserted.
    function automatic logic is_expired(input state_t s);
        return (s == ST_TIMEOUT) || (s == ST_HUNG);
    endfunction

endpackage

// File: rtl/watchdog_rr_arbiter.sv
// Round-robin arbiter for the watchdog command port. The search starts at the
// pointer and wraps; the pointer moves past the winner only when advance_i is set.
module watchdog_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_valid_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;
    int              pos;

    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        pos         = 0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = ID_W'(pos);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx;
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_id_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && gnt_valid_o) begin
            ptr_d = (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/watchdog_controller.sv
// Shared watchdog: arbitrated ARM/KICK/DISARM/ACK commands drive one timeout
// counter, then a post-timeout window that ends in a sticky hung flag.
//
// state   | meaning
// IDLE    | not armed, counter held at zero
// ARMED   | main counter running down toward expiry
// TIMEOUT | expired, waiting for ACK while the post window counts down
// HUNG    | nobody acknowledged in time; left only through reset
module watchdog_controller
    import watchdog_ctrl_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int COUNTER_WIDTH      = 64,
    parameter int POST_COUNTER_WIDTH = 8,
    parameter int ID_W               = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_cmd,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [COUNTER_WIDTH-1:0]      cfg_timeout,
    input  logic [POST_COUNTER_WIDTH-1:0] cfg_post,
    output logic                          timeout,
    output logic                          hung,
    output logic [1:0]                    state,
    output logic [COUNTER_WIDTH-1:0]      count,
    output logic [ID_W-1:0]               last_owner,
    output logic                          cmd_err
);

    state_t                        state_q, state_d;
    logic [COUNTER_WIDTH-1:0]      count_q, count_d;
    logic [POST_COUNTER_WIDTH-1:0] post_q, post_d;
    logic                          hung_q, hung_d;
    logic                          timeout_q, timeout_d;
    logic                          err_q, err_d;
    logic [ID_W-1:0]               owner_q, owner_d;

    logic [NUM_REQ-1:0]            gnt;
    logic [ID_W-1:0]               gnt_id;
    logic                          gnt_valid;
    cmd_t                          cmd;

    // Ready is only ever offered to a valid requester, so every grant is a transfer.
    watchdog_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_valid),
        .advance_i   (gnt_valid),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    assign req_ready = gnt;

    always_comb begin
        cmd = cmd_t'(req_cmd[{gnt_id, 1'b0} +: 2]);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        post_d  = post_q;
        hung_d  = hung_q;
        err_d   = 1'b0;
        owner_d = gnt_valid ? gnt_id : owner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    if (cmd == CMD_ARM) begin
                        count_d = cfg_timeout;
                        state_d = ST_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                // An accepted command always wins over expiry in the same cycle.
                if (gnt_valid) begin
                    unique case (cmd)
                        CMD_ARM, CMD_KICK: count_d = cfg_timeout;
                        CMD_DISARM: begin
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                        CMD_ACK: err_d = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end else if (count_q == '0) begin
                    post_d  = cfg_post;
                    state_d = ST_TIMEOUT;
                end else begin
                    count_d = count_q - COUNTER_WIDTH'(1);
                end
            end
            ST_TIMEOUT: begin
                if (gnt_valid && cmd == CMD_ACK) begin
                    count_d = '0;
                    post_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    err_d = gnt_valid;
                    if (post_q == '0) begin
                        hung_d  = 1'b1;
                        state_d = ST_HUNG;
                    end else begin
                        post_d = post_q - POST_COUNTER_WIDTH'(1);
                    end
                end
            end
            ST_HUNG: begin
                err_d = gnt_valid;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        timeout_d = is_expired(state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            post_q    <= '0;
            hung_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            post_q    <= post_d;
            hung_q    <= hung_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            owner_q   <= owner_d;
        end
    end

    assign state      = state_q;
    assign count      = count_q;
    assign hung       = hung_q;
    assign timeout    = timeout_q;
    assign cmd_err    = err_q;
    assign last_owner = owner_q;

endmodule
